// File: rtl/interval_decode_pkg.sv
// Shared types and constants for the interval decoder.
// Covers the FP format helpers used to size values and pick the canonical NaN.
package interval_pkg;

  localparam int NUM_DEFAULT = 8;

  typedef logic [$clog2(NUM_DEFAULT)-1:0] idx_t;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  function automatic int unsigned exp_bits(fp_format_e f);
    case (f)
      FP32:    return 8;
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      FP16ALT: return 8;
      default: return 5;
    endcase
  endfunction

  function automatic int unsigned man_bits(fp_format_e f);
    case (f)
      FP32:    return 23;
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 2;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e f);
    return 1 + exp_bits(f) + man_bits(f);
  endfunction

  // Quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
  function automatic logic [63:0] canon_nan(fp_format_e f);
    logic [63:0] e_ones;
    logic [63:0] q_bit;
    e_ones = ((64'd1 << exp_bits(f)) - 64'd1) << man_bits(f);
    q_bit  = 64'd1 << (man_bits(f) - 1);
    return e_ones | q_bit;
  endfunction

  localparam logic [31:0] CANON_NAN_FP32    = 32'h7FC0_0000;
  localparam logic [63:0] CANON_NAN_FP64    = 64'h7FF8_0000_0000_0000;
  localparam logic [15:0] CANON_NAN_FP16    = 16'h7E00;
  localparam logic [7:0]  CANON_NAN_FP8     = 8'h7E;
  localparam logic [15:0] CANON_NAN_FP16ALT = 16'h7FC0;

endpackage

// File: rtl/interval_decode_if.sv
// Handshake, codebook-write and status bundle of the interval decoder.
// The decoder sits on the slave side; the producer/consumer on the master side.
interface interval_decode_if #(
  parameter int NUM   = 8,
  parameter int WIDTH = 8
);

  localparam int AW = $clog2(NUM);

  logic [NUM-1:0]   interval_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] value_o;
  logic             err_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             cb_we_i;
  logic [AW-1:0]    cb_addr_i;
  logic [WIDTH-1:0] cb_wdata_i;
  logic [7:0]       err_cnt_o;

  modport master (
    output interval_i,
    output in_valid_i,
    input  in_ready_o,
    input  value_o,
    input  err_o,
    input  out_valid_o,
    output out_ready_i,
    output cb_we_i,
    output cb_addr_i,
    output cb_wdata_i,
    input  err_cnt_o
  );

  modport slave (
    input  interval_i,
    input  in_valid_i,
    output in_ready_o,
    output value_o,
    output err_o,
    output out_valid_o,
    input  out_ready_i,
    input  cb_we_i,
    input  cb_addr_i,
    input  cb_wdata_i,
    output err_cnt_o
  );

endinterface

// File: rtl/interval_decode_onehot.sv
// One-hot code to binary index plus a legality flag (exactly one bit set).
// Purely combinational; the index is meaningless when legal is low.
module onehot_to_idx #(
  parameter int NUM = 8,
  localparam int IW = $clog2(NUM)
) (
  input  logic [NUM-1:0] code,
  output logic [IW-1:0]  idx,
  output logic           legal
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM; i++) begin
      if (code[i]) begin
        idx = idx | IW'(i);
      end
    end
  end

  assign legal = $onehot(code);

endmodule

// File: rtl/interval_decode.sv
// Two-stage one-hot interval decoder: S1 registers index/legality,
// S2 registers the codebook value (or canonical NaN) and the error flag.
module interval_decode
  import interval_pkg::*;
#(
  parameter int         NUM      = NUM_DEFAULT,
  parameter fp_format_e FpFormat = fp_format_e'(3)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  interval_decode_if.slave  bus
);

  localparam int WIDTH = fp_width(FpFormat);
  localparam int IW    = $clog2(NUM);

  localparam logic [WIDTH-1:0] NAN_VAL = WIDTH'(canon_nan(FpFormat));
  localparam logic [IW:0]      NUM_L   = (IW+1)'(NUM);

  logic [IW-1:0]    idx_c;
  logic             legal_c;

  logic             s1_valid;
  logic             s1_legal;
  logic [IW-1:0]    s1_idx;

  logic             s2_valid;
  logic             s2_err;
  logic [WIDTH-1:0] s2_value;

  logic [WIDTH-1:0] cb [NUM];
  logic [7:0]       err_cnt;

  logic             s2_accept;
  logic             s1_accept;
  logic             in_fire;
  logic             cb_wr;

  onehot_to_idx #(
    .NUM (NUM)
  ) u_onehot (
    .code  (bus.interval_i),
    .idx   (idx_c),
    .legal (legal_c)
  );

  assign s2_accept = !s2_valid || bus.out_ready_i;
  assign s1_accept = !s1_valid || s2_accept;
  assign in_fire   = bus.in_valid_i && s1_accept;
  assign cb_wr     = bus.cb_we_i && ({1'b0, bus.cb_addr_i} < NUM_L);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_legal <= 1'b0;
      s1_idx   <= '0;
    end else if (s1_accept) begin
      s1_valid <= bus.in_valid_i;
      if (bus.in_valid_i) begin
        s1_legal <= legal_c;
        s1_idx   <= idx_c;
      end
    end
  end

  // Lookup reads the pre-edge codebook, so a same-edge write is not seen.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      s2_err   <= 1'b0;
      s2_value <= '0;
    end else if (s2_accept) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_err   <= !s1_legal;
        s2_value <= s1_legal ? cb[s1_idx] : NAN_VAL;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM; i++) begin
        cb[i] <= '0;
      end
    end else if (cb_wr) begin
      cb[bus.cb_addr_i] <= bus.cb_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt <= '0;
    end else if (in_fire && !legal_c && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign bus.in_ready_o  = s1_accept;
  assign bus.out_valid_o = s2_valid;
  assign bus.value_o     = s2_value;
  assign bus.err_o       = s2_err;
  assign bus.err_cnt_o   = err_cnt;

endmodule

// File: tb/tb_interval_decode.sv
// Directed bench for interval_decode: reset, streaming, errors,
// backpressure, same-edge codebook write, mid-flight reset, saturation.
module tb_interval_decode;
  import interval_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  interval_decode_if #(.NUM(8), .WIDTH(8)) bus ();

  interval_decode #(
    .NUM      (8),
    .FpFormat (FP8)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.interval_i  = '0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.cb_we_i     = 1'b0;
    bus.cb_addr_i   = '0;
    bus.cb_wdata_i  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int   sent;
    int   rcv;
    logic fire;

    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid_o, 0);
    check("rst_value", bus.value_o, 0);
    check("rst_err", bus.err_o, 0);
    check("rst_err_cnt", bus.err_cnt_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready_o, 1);

    // codebook[k] = 0x10 + k
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.cb_we_i    = 1'b1;
      bus.cb_addr_i  = 3'(k);
      bus.cb_wdata_i = 8'(8'h10 + k);
    end
    @(negedge clk);
    bus.cb_we_i = 1'b0;

    // streaming with out_ready high
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 2) begin
        check("stream_lat", bus.out_valid_o, 0);
      end else begin
        check("stream_valid", bus.out_valid_o, 1);
        check("stream_value", bus.value_o, 32'(8'h10 + k - 2));
        check("stream_err", bus.err_o, 0);
      end
      if (k < 8) begin
        bus.in_valid_i = 1'b1;
        bus.interval_i = 8'(1 << k);
      end else begin
        bus.in_valid_i = 1'b0;
      end
    end
    @(negedge clk);
    check("stream_drain", bus.out_valid_o, 0);

    // non-one-hot codes
    for (int k = 0; k < 4; k++) begin
      if (k >= 2) begin
        check("bad_valid", bus.out_valid_o, 1);
        check("bad_value", bus.value_o, 32'h7E);
        check("bad_err", bus.err_o, 1);
      end
      bus.in_valid_i = (k < 2);
      bus.interval_i = (k == 0) ? 8'h00 : 8'h03;
      @(negedge clk);
    end
    check("bad_err_cnt", bus.err_cnt_o, 2);

    // backpressure: out_ready low for 5 cycles
    sent = 0;
    rcv  = 0;
    fire = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.interval_i = 8'h01;
    for (int c = 0; c < 60 && rcv < 8; c++) begin
      if (fire) begin
        sent++;
        bus.in_valid_i = (sent < 8);
        bus.interval_i = 8'(1 << sent);
      end
      bus.out_ready_i = (c >= 5);
      bus.cb_we_i     = (c == 2);
      bus.cb_addr_i   = 3'd0;
      bus.cb_wdata_i  = 8'h99;
      #1;
      if (c == 4) begin
        check("bp_accepted", sent, 2);
        check("bp_in_ready", bus.in_ready_o, 0);
        check("bp_s2_hold", bus.value_o, 32'h10);
      end
      fire = bus.in_valid_i && bus.in_ready_o;
      if (bus.out_valid_o && bus.out_ready_i) begin
        check("bp_value", bus.value_o, 32'(8'h10 + rcv));
        rcv++;
      end
      @(negedge clk);
    end
    check("bp_count", rcv, 8);
    check("bp_no_dup", bus.out_valid_o, 0);
    bus.in_valid_i = 1'b0;

    // codebook write on the S1->S2 edge of a 0x08 beat
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.interval_i  = 8'h08;
    @(negedge clk);
    bus.cb_we_i    = 1'b1;
    bus.cb_addr_i  = 3'd3;
    bus.cb_wdata_i = 8'h55;
    @(negedge clk);
    bus.cb_we_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    check("wr_old_valid", bus.out_valid_o, 1);
    check("wr_old_value", bus.value_o, 32'h13);
    @(negedge clk);
    check("wr_new_valid", bus.out_valid_o, 1);
    check("wr_new_value", bus.value_o, 32'h55);
    @(negedge clk);

    // reset with two beats in flight
    bus.in_valid_i = 1'b1;
    bus.interval_i = 8'h01;
    @(negedge clk);
    bus.interval_i = 8'h02;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    #2;
    check("rrst_pre_valid", bus.out_valid_o, 1);
    rst_n = 1'b0;
    #1;
    check("rrst_valid", bus.out_valid_o, 0);
    check("rrst_err_cnt", bus.err_cnt_o, 0);
    check("rrst_value", bus.value_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rrst_no_ghost", bus.out_valid_o, 0);
    end
    bus.in_valid_i = 1'b1;
    bus.interval_i = 8'h08;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    check("rrst_cb_valid", bus.out_valid_o, 1);
    check("rrst_cb_value", bus.value_o, 0);
    check("rrst_cb_err", bus.err_o, 0);

    // 300 non-one-hot beats saturate the counter
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 100) check("sat_100", bus.err_cnt_o, 100);
      if (i == 254) check("sat_254", bus.err_cnt_o, 254);
      if (i == 255) check("sat_255", bus.err_cnt_o, 255);
      if (i == 256) check("sat_256", bus.err_cnt_o, 255);
      bus.in_valid_i = 1'b1;
      bus.interval_i = i[0] ? 8'hFF : 8'h00;
    end
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    check("sat_final", bus.err_cnt_o, 255);
    check("sat_value", bus.value_o, 32'h7E);
    check("sat_err", bus.err_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
